// File: rtl/pass_candidate_gen.sv
// Password candidate enumerator: walks every string over a programmable charset
// for lengths len_min..len_max and offers each as a 192-bit word on a valid/ready port.
module pass_candidate_gen #(
  parameter int MAX_LEN  = 12,
  parameter int CS_DEPTH = 64,
  parameter int CNT_W    = 48
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_cs_we,
  input  logic [5:0]         i_cs_addr,
  input  logic [7:0]         i_cs_data,
  input  logic [6:0]         i_cs_size,
  input  logic [3:0]         i_len_min,
  input  logic [3:0]         i_len_max,
  input  logic               i_start,
  input  logic               i_pass_ready,
  output logic               o_pass_valid,
  output logic [191:0]       o_pass,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [CNT_W-1:0]   o_count
);

  // state   | meaning
  // IDLE    | waiting for start, outputs hold last result
  // BUILD   | format current index vector into the password word
  // OFFER   | word valid, waiting for the hash core to accept
  // ADVANCE | step the odometer, finish after the longest length wraps
  typedef enum logic [1:0] {S_IDLE, S_BUILD, S_OFFER, S_ADVANCE} state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_cs [CS_DEPTH];
  logic [5:0]       r_idx [MAX_LEN];
  logic [5:0]       w_idx_nxt [MAX_LEN];
  logic [3:0]       r_len, r_len_max;
  logic [6:0]       r_cs_size;
  logic [191:0]     r_pass;
  logic             r_valid, r_done, r_err;
  logic [CNT_W-1:0] r_count;
  logic             w_busy, w_cfg_ok, w_carry, w_last;

  assign w_busy   = (r_state != S_IDLE);
  assign w_cfg_ok = (i_cs_size != 7'd0) && (i_cs_size <= 7'd64) && (i_len_min != 4'd0) &&
                    (i_len_max <= 4'd12) && (i_len_min <= i_len_max);

  // Charset table is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (i_cs_we && !w_busy) r_cs[i_cs_addr] <= i_cs_data;
  end

  // Odometer: w_carry survives only if every active position wrapped.
  always_comb begin
    w_carry = 1'b1;
    for (int k = 0; k < MAX_LEN; k++) begin
      w_idx_nxt[k] = r_idx[k];
      if ((4'(k) < r_len) && w_carry) begin
        if ({1'b0, r_idx[k]} == (r_cs_size - 7'd1)) begin
          w_idx_nxt[k] = 6'd0;
        end else begin
          w_idx_nxt[k] = r_idx[k] + 6'd1;
          w_carry      = 1'b0;
        end
      end
    end
    w_last = w_carry && (r_len == r_len_max);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_start && w_cfg_ok) w_state_nxt = S_BUILD;
      S_BUILD:   w_state_nxt = S_OFFER;
      S_OFFER:   if (i_pass_ready) w_state_nxt = S_ADVANCE;
      S_ADVANCE: w_state_nxt = w_last ? S_IDLE : S_BUILD;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state   <= S_IDLE;
      r_pass    <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_count   <= '0;
      r_len     <= 4'd0;
      r_len_max <= 4'd0;
      r_cs_size <= 7'd0;
      for (int k = 0; k < MAX_LEN; k++) r_idx[k] <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cs_size <= i_cs_size;
            r_len     <= i_len_min;
            r_len_max <= i_len_max;
            for (int k = 0; k < MAX_LEN; k++) r_idx[k] <= 6'd0;
            if (w_cfg_ok) begin
              r_err   <= 1'b0;
              r_done  <= 1'b0;
              r_count <= '0;
            end else begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end
          end
        end
        S_BUILD: begin
          for (int k = 0; k < MAX_LEN; k++)
            r_pass[191-16*k -: 16] <= (4'(k) < r_len) ? {r_cs[r_idx[k]], 8'h00} : 16'h0000;
          r_valid <= 1'b1;
        end
        S_OFFER: begin
          if (i_pass_ready) begin
            r_valid <= 1'b0;
            r_count <= r_count + 1'b1;
          end
        end
        S_ADVANCE: begin
          // A full wrap leaves every index at zero, which is the start of the next length.
          for (int k = 0; k < MAX_LEN; k++) r_idx[k] <= w_idx_nxt[k];
          if (w_last)       r_done <= 1'b1;
          else if (w_carry) r_len  <= r_len + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_pass_valid = r_valid;
  assign o_pass       = r_pass;
  assign o_busy       = w_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_count      = r_count;

endmodule

// File: tb/tb_pass_candidate_gen.sv
// Self-checking bench for pass_candidate_gen: expected candidate lists come from a
// base-cs_size counting model over the shadow charset.
module tb_pass_candidate_gen;

  logic         clk = 1'b0;
  logic         i_rstn = 1'b0;
  logic         i_cs_we = 1'b0;
  logic [5:0]   i_cs_addr = '0;
  logic [7:0]   i_cs_data = '0;
  logic [6:0]   i_cs_size = '0;
  logic [3:0]   i_len_min = '0;
  logic [3:0]   i_len_max = '0;
  logic         i_start = 1'b0;
  logic         i_pass_ready = 1'b0;
  logic         o_pass_valid;
  logic [191:0] o_pass;
  logic         o_busy, o_done, o_err;
  logic [47:0]  o_count;

  int checks = 0;
  int failures = 0;
  logic [7:0]   sh_cs [64];
  logic [191:0] got [$];
  logic [191:0] exp_q [$];

  always #5 clk = ~clk;

  pass_candidate_gen dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_cs_we(i_cs_we), .i_cs_addr(i_cs_addr),
    .i_cs_data(i_cs_data), .i_cs_size(i_cs_size), .i_len_min(i_len_min),
    .i_len_max(i_len_max), .i_start(i_start), .i_pass_ready(i_pass_ready),
    .o_pass_valid(o_pass_valid), .o_pass(o_pass), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_count(o_count)
  );

  function automatic logic [191:0] model_word(input int size, input int len, input longint n);
    logic [191:0] w;
    longint v;
    w = '0;
    v = n;
    for (int k = 0; k < len; k++) begin
      w[191-16*k -: 8] = sh_cs[int'(v % size)];
      v = v / size;
    end
    return w;
  endfunction

  task automatic build_expected(input int size, input int lmin, input int lmax);
    longint total;
    exp_q.delete();
    for (int len = lmin; len <= lmax; len++) begin
      total = 1;
      for (int j = 0; j < len; j++) total = total * size;
      for (longint n = 0; n < total; n++) exp_q.push_back(model_word(size, len, n));
    end
  endtask

  task automatic cs_write(input int addr, input logic [7:0] data);
    i_cs_we = 1'b1; i_cs_addr = 6'(addr); i_cs_data = data;
    @(negedge clk);
    i_cs_we = 1'b0;
    sh_cs[addr] = data;
  endtask

  task automatic do_start(input int size, input int lmin, input int lmax);
    i_cs_size = 7'(size); i_len_min = 4'(lmin); i_len_max = 4'(lmax);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Drives ready and records every transferred word; no checking here.
  task automatic collect(input int max_xfers, input bit rand_ready, input int budget,
                         output bit to);
    bit rdy;
    int cyc;
    cyc = 0;
    to = 1'b0;
    got.delete();
    forever begin
      @(negedge clk);
      if (got.size() >= max_xfers || (o_done && !o_busy)) break;
      if (cyc >= budget) begin to = 1'b1; break; end
      cyc++;
      rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (o_pass_valid && rdy) got.push_back(o_pass);
      i_pass_ready = rdy;
    end
    i_pass_ready = 1'b0;
  endtask

  task automatic test_reset;
    i_rstn = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({o_pass_valid, o_busy, o_done, o_err} !== 4'b0000 || o_pass !== '0 || o_count !== '0) begin
      failures++;
      $display("FAIL reset: valid=%b busy=%b done=%b err=%b count=%0d pass_nonzero=%b, required all 0",
               o_pass_valid, o_busy, o_done, o_err, o_count, |o_pass);
    end
    i_rstn = 1'b1;
  endtask

  task automatic test_basic;
    bit to;
    cs_write(0, 8'h61); cs_write(1, 8'h62);
    build_expected(2, 1, 2);
    do_start(2, 1, 2);
    checks++;
    if (o_pass_valid !== 1'b0 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency1: valid=%b busy=%b, required valid=0 busy=1", o_pass_valid, o_busy);
    end
    @(negedge clk);
    checks++;
    if (o_pass_valid !== 1'b1 || o_pass !== exp_q[0]) begin
      failures++;
      $display("FAIL basic_latency2: valid=%b pass=%h, required valid=1 pass=%h", o_pass_valid, o_pass, exp_q[0]);
    end
    collect(100, 1'b0, 200, to);
    checks++;
    if (to || got.size() != 6) begin
      failures++;
      $display("FAIL basic_len: timeout=%b got=%0d, required 6", to, got.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL basic_word[%0d]: got %h, required %h", i, got[i], exp_q[i]);
      end
    end
    checks++;
    if (exp_q[3] !== {16'h6200, 16'h6100, 160'h0}) begin
      failures++;
      $display("FAIL basic_model_ba: model %h, required 6200_6100_0", exp_q[3]);
    end
    checks++;
    if (o_count !== 48'd6 || o_done !== 1'b1 || o_busy !== 1'b0 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL basic_end: count=%0d done=%b busy=%b err=%b, required 6 1 0 0",
               o_count, o_done, o_busy, o_err);
    end
  endtask

  task automatic test_stall;
    bit to;
    logic [191:0] all [$];
    logic [191:0] held;
    int w;
    build_expected(2, 1, 2);
    do_start(2, 1, 2);
    collect(2, 1'b0, 50, to);
    all = got;
    w = 0;
    while (!o_pass_valid && w < 10) begin @(negedge clk); w++; end
    held = o_pass;
    checks++;
    if (!o_pass_valid || held !== {16'h6100, 16'h6100, 160'h0} || o_err !== 1'b0) begin
      failures++;
      $display("FAIL stall_third: valid=%b pass=%h err=%b, required valid=1 aa err=0", o_pass_valid, held, o_err);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (o_pass_valid !== 1'b1 || o_pass !== held || o_count !== 48'd2) begin
        failures++;
        $display("FAIL stall_hold[%0d]: valid=%b pass=%h count=%0d, required 1 %h 2",
                 c, o_pass_valid, o_pass, o_count, held);
      end
    end
    collect(100, 1'b0, 200, to);
    foreach (got[i]) all.push_back(got[i]);
    checks++;
    if (to || all.size() != 6) begin
      failures++;
      $display("FAIL stall_len: timeout=%b got=%0d, required 6", to, all.size());
    end
    for (int i = 0; i < all.size() && i < exp_q.size(); i++) begin
      checks++;
      if (all[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL stall_word[%0d]: got %h, required %h", i, all[i], exp_q[i]);
      end
    end
    checks++;
    if (o_count !== 48'd6) begin
      failures++;
      $display("FAIL stall_count: got %0d, required 6", o_count);
    end
  endtask

  task automatic test_illegal;
    int sz [3] = '{0, 2, 2};
    int mn [3] = '{1, 3, 1};
    int mx [3] = '{2, 2, 13};
    i_rstn = 1'b0; @(negedge clk); i_rstn = 1'b1;
    for (int t = 0; t < 3; t++) begin
      do_start(sz[t], mn[t], mx[t]);
      for (int c = 0; c < 6; c++) begin
        checks++;
        if (o_pass_valid !== 1'b0 || o_busy !== 1'b0) begin
          failures++;
          $display("FAIL illegal%0d_quiet: valid=%b busy=%b, required 0 0", t, o_pass_valid, o_busy);
        end
        @(negedge clk);
      end
      checks++;
      if (o_err !== 1'b1 || o_done !== 1'b1 || o_count !== 48'd0) begin
        failures++;
        $display("FAIL illegal%0d_flags: err=%b done=%b count=%0d, required 1 1 0", t, o_err, o_done, o_count);
      end
    end
  endtask

  task automatic test_single12;
    bit to;
    cs_write(0, 8'h7a);
    do_start(1, 12, 12);
    collect(10, 1'b0, 50, to);
    checks++;
    if (to || got.size() != 1 || got[0] !== {12{16'h7a00}}) begin
      failures++;
      $display("FAIL single12: timeout=%b n=%0d first=%h, required 1 x 7a00*12", to, got.size(),
               got.size() > 0 ? got[0] : 192'h0);
    end
    checks++;
    if (o_count !== 48'd1 || o_done !== 1'b1 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL single12_end: count=%0d done=%b err=%b, required 1 1 0", o_count, o_done, o_err);
    end
  endtask

  task automatic test_reset_midrun;
    bit to;
    cs_write(0, 8'h61); cs_write(1, 8'h62);
    build_expected(2, 1, 2);
    do_start(2, 1, 2);
    collect(2, 1'b0, 50, to);
    i_rstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_pass_valid, o_busy, o_done, o_err} !== 4'b0000 || o_pass !== '0 || o_count !== '0) begin
      failures++;
      $display("FAIL midrun_reset: valid=%b busy=%b done=%b err=%b count=%0d, required all 0",
               o_pass_valid, o_busy, o_done, o_err, o_count);
    end
    i_rstn = 1'b1;
    do_start(2, 1, 2);
    i_cs_we = 1'b1; i_cs_addr = 6'd0; i_cs_data = 8'h7a;
    @(negedge clk);
    i_cs_we = 1'b0;
    collect(100, 1'b0, 200, to);
    checks++;
    if (to || got.size() != 6 || got[0] !== {16'h6100, 176'h0}) begin
      failures++;
      $display("FAIL midrun_restart: timeout=%b n=%0d first=%h, required 6 starting with a",
               to, got.size(), got.size() > 0 ? got[0] : 192'h0);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL midrun_word[%0d]: got %h, required %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_busy;
    bit to;
    build_expected(2, 1, 2);
    do_start(2, 1, 2);
    @(negedge clk);
    i_cs_size = 7'd1; i_len_min = 4'd12; i_len_max = 4'd12; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    collect(100, 1'b0, 200, to);
    checks++;
    if (to || got.size() != 6 || o_count !== 48'd6) begin
      failures++;
      $display("FAIL busy_start: timeout=%b n=%0d count=%0d, required 6 6", to, got.size(), o_count);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL busy_start_word[%0d]: got %h, required %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random;
    bit to;
    int size, lmin, lmax, bad;
    for (int it = 0; it < 4; it++) begin
      size = $urandom_range(1, 6);
      lmin = $urandom_range(1, 3);
      lmax = $urandom_range(lmin, 3);
      for (int a = 0; a < size; a++) cs_write(a, 8'($urandom_range(1, 255)));
      build_expected(size, lmin, lmax);
      do_start(size, lmin, lmax);
      collect(100000, 1'b1, 5000, to);
      bad = 0;
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          failures++;
          bad++;
          if (bad < 4) $display("FAIL rand%0d_word[%0d]: got %h, required %h", it, i, got[i], exp_q[i]);
        end
      end
      checks++;
      if (to || got.size() != exp_q.size() || o_count !== 48'(exp_q.size()) || o_done !== 1'b1) begin
        failures++;
        $display("FAIL rand%0d_end: timeout=%b n=%0d count=%0d done=%b, required n=count=%0d done=1",
                 it, to, got.size(), o_count, o_done, exp_q.size());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_stall;
    test_illegal;
    test_single12;
    test_reset_midrun;
    test_start_busy;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pass_candidate_gen.md
Name: pass_candidate_gen

Overview:
- Brute-force password candidate enumerator that sits directly upstream of the PBKDF2-HMAC-Whirlpool hash core.
- Walks every string over a programmable charset for lengths len_min..len_max.
- Formats each string into the core's 192-bit password word and offers it with a valid/ready handshake.
- Counts accepted candidates and flags completion.

Parameters:
- MAX_LEN, 12, maximum password length in characters (fixed by the 192-bit password word).
- CS_DEPTH, 64, charset table entries.
- CNT_W, 48, width of the accepted-candidate counter.

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rstn  in  1  synchronous active-low reset
- i_cs_we  in  1  charset write strobe; ignored while o_busy=1
- i_cs_addr  in  6  charset write index
- i_cs_data  in  8  character byte
- i_cs_size  in  7  number of valid charset entries; legal 1..64; sampled on start
- i_len_min  in  4  shortest length; legal 1..12; sampled on start
- i_len_max  in  4  longest length; legal len_min..12; sampled on start
- i_start  in  1  one-cycle start pulse; ignored while o_busy=1
- i_pass_ready  in  1  hash core idle/accepting (drives core i_ena_hash side)
- o_pass_valid  out  1  candidate on o_pass is valid
- o_pass  out  192  candidate word
- o_busy  out  1  enumeration in progress
- o_done  out  1  sticky: enumeration finished; cleared by next accepted start
- o_err  out  1  sticky: last start had an illegal configuration
- o_count  out  48  candidates accepted since last start

Behaviour:
- Reset (synchronous, i_rstn=0 at clock edge): state=IDLE. o_pass_valid=0, o_pass=0, o_busy=0, o_done=0, o_err=0, o_count=0. Charset table contents are not reset.
- Charset: 64x8 register array. Written when i_cs_we=1 and o_busy=0.
- Word format:
  - Character position k (0 = first) goes in o_pass[191-16k -: 8].
  - o_pass[183-16k -: 8] = 0.
  - Positions k >= current length are 0.
- Enumeration order:
  - Index vector idx[0..11], each 6 bits; position 0 is least significant (fastest).
  - Start at length L=len_min, all idx=0.
  - Advance: idx[0]++. When idx[j] reaches cs_size-1 and increments, it wraps to 0 and carries into idx[j+1], considering positions < L only.
  - Carry out of position L-1 means L++ with all idx=0.
  - If L would exceed len_max, enumeration is finished.
- States:
  - IDLE: on i_start, latch cs_size, len_min, len_max.
    - Illegal config (cs_size=0 or >64, len_min=0, len_max>12, len_min>len_max): o_err=1, o_done=1, o_busy=0, stay IDLE.
    - Legal config: o_err=0, o_done=0, o_count=0, o_busy=1, go to BUILD.
  - BUILD: register o_pass from charset[idx[k]] for k<L. Go to OFFER; o_pass_valid=1 on the next cycle.
  - OFFER: hold o_pass and o_pass_valid stable until a cycle with i_pass_ready=1. That cycle is the transfer: o_count++, o_pass_valid=0 next cycle, go to ADVANCE.
  - ADVANCE: step the odometer.
    - Finished: o_busy=0, o_done=1, go to IDLE.
    - Otherwise go to BUILD.
- Latency:
  - i_start to first o_pass_valid high: 2 cycles.
  - Transfer cycle to next o_pass_valid high: 3 cycles.
  - After the last transfer, o_done rises 2 cycles later.
- Candidates emitted = sum over L=len_min..len_max of cs_size^L. o_count wraps modulo 2^48 and takes no other action.
- i_pass_ready is don't-care outside OFFER. i_start during o_busy=1 has no effect. o_pass retains its last value after done.
- Reset mid-operation returns to the reset values above at the next edge; no partial candidate is emitted.

Test Plan:
- Charset {0x61,0x62}, cs_size=2, len 1..2, i_pass_ready=1 -> o_pass character bytes in order: a, b, aa, ba, ab, bb (e.g. "ba" = o_pass[191:176]=16'h6200, o_pass[175:160]=16'h6100, rest 0). Then o_count=6, o_done=1, o_busy=0, o_err=0.
- Same config, i_pass_ready held low 10 cycles during the 3rd offer -> o_pass=16'h6100,16'h6100 and o_pass_valid=1 held stable all 10 cycles; o_count unchanged until ready; no candidate skipped or duplicated.
- cs_size=1 (entry 0x7A), len 12..12 -> exactly one candidate, all 12 slots = 16'h7A00. o_count=1, o_done=1.
- Illegal starts (cs_size=0; len_min=3 with len_max=2; len_max=13) -> o_err=1, o_done=1, o_pass_valid never asserts, o_count=0.
- Reset mid-run after 2 transfers -> next cycle all outputs at reset values. New start regenerates from first candidate "a". i_cs_we while busy leaves charset unchanged (verify via output bytes).
- i_start pulse while busy -> ignored; enumeration sequence and final o_count identical to the undisturbed run.
